// File: rtl/layered_color_mapper.sv
// layered_color_mapper
// Resolves NUM_LAYERS prioritised shape layers per pixel, looks the winning
// layer's color index up in a writable 24-bit palette and emits the color
// two cycles later. Layers flagged in blink_en are hidden while blink_phase
// is high; blink_phase toggles every BLINK_FRAMES frames. Pixels outside the
// active area are forced to black.
module layered_color_mapper #(
    parameter int NUM_LAYERS   = 4,
    parameter int IDX_W        = 4,
    parameter int BLINK_FRAMES = 30,
    parameter int H_ACTIVE     = 640,
    parameter int V_ACTIVE     = 480
) (
    input  logic                        Clk,
    input  logic                        Reset_n,
    input  logic                        pix_valid,
    input  logic [9:0]                  DrawX,
    input  logic [9:0]                  DrawY,
    input  logic [NUM_LAYERS-1:0]       layer_hit,
    input  logic [NUM_LAYERS*IDX_W-1:0] layer_idx,
    input  logic [NUM_LAYERS-1:0]       blink_en,
    input  logic                        pal_we,
    input  logic [IDX_W-1:0]            pal_addr,
    input  logic [23:0]                 pal_wdata,
    output logic [7:0]                  VGA_R,
    output logic [7:0]                  VGA_G,
    output logic [7:0]                  VGA_B,
    output logic                        out_valid,
    output logic                        blink_phase
);

    localparam int PAL_N = 2 ** IDX_W;
    localparam int CNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_FRAMES - 1);
    localparam logic [9:0] H_LIM = 10'(H_ACTIVE);
    localparam logic [9:0] V_LIM = 10'(V_ACTIVE);

    // Lowest-numbered hit layer wins; no hit falls back to background index 0.
    function automatic logic [IDX_W-1:0] select_idx(
        input logic [NUM_LAYERS-1:0]       hit,
        input logic [NUM_LAYERS*IDX_W-1:0] idx
    );
        logic [IDX_W-1:0] sel;
        sel = '0;
        for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
            if (hit[i]) begin
                sel = idx[i*IDX_W +: IDX_W];
            end
        end
        return sel;
    endfunction

    // Power-up palette: red background, white foreground, rest black.
    function automatic logic [23:0] pal_reset_value(input int entry);
        logic [23:0] val;
        case (entry)
            0:       val = 24'hFF0000;
            1:       val = 24'hFFFFFF;
            default: val = 24'h000000;
        endcase
        return val;
    endfunction

    logic [CNT_W-1:0]      frame_cnt;
    logic [23:0]           palette [PAL_N];
    logic [NUM_LAYERS-1:0] eff_hit;
    logic                  frame_start;
    logic [IDX_W-1:0]      sel_idx;
    logic                  blank;

    logic                  vld_p1;
    logic [IDX_W-1:0]      idx_p1;
    logic                  blank_p1;
    logic [23:0]           pal_rd;
    logic [23:0]           rgb_p2;

    assign eff_hit     = layer_hit & ~(blink_en & {NUM_LAYERS{blink_phase}});
    assign frame_start = pix_valid && (DrawX == 10'd0) && (DrawY == 10'd0);
    assign sel_idx     = select_idx(eff_hit, layer_idx);
    assign blank       = (DrawX >= H_LIM) || (DrawY >= V_LIM);

    // Frame counter and blink phase advance on the first pixel of each frame;
    // that pixel itself still sees the old phase.
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            frame_cnt   <= '0;
            blink_phase <= 1'b0;
        end else if (frame_start) begin
            if (frame_cnt == CNT_LAST) begin
                frame_cnt   <= '0;
                blink_phase <= ~blink_phase;
            end else begin
                frame_cnt <= frame_cnt + CNT_W'(1);
            end
        end
    end

    // Palette storage: restored on reset, single write port otherwise.
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            for (int i = 0; i < PAL_N; i++) begin
                palette[i] <= pal_reset_value(i);
            end
        end else if (pal_we) begin
            palette[pal_addr] <= pal_wdata;
        end
    end

    // ---- stage 1: priority-resolved index and blank flag ----
    // Valid tracks pix_valid every cycle; payload only loads on valid pixels.
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            vld_p1 <= 1'b0;
        end else begin
            vld_p1 <= pix_valid;
        end
        if (pix_valid) begin
            idx_p1   <= sel_idx;
            blank_p1 <= blank;
        end
    end

    // Read happens before any same-edge write lands, so a colliding write
    // is seen only by later pixels.
    assign pal_rd = palette[idx_p1];

    // ---- stage 2: palette lookup / blanking into the output color ----
    // Color holds its last value whenever no pixel is emitted.
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            out_valid <= 1'b0;
            rgb_p2    <= 24'h000000;
        end else begin
            out_valid <= vld_p1;
            if (vld_p1) begin
                rgb_p2 <= blank_p1 ? 24'h000000 : pal_rd;
            end
        end
    end

    assign VGA_R = rgb_p2[23:16];
    assign VGA_G = rgb_p2[15:8];
    assign VGA_B = rgb_p2[7:0];

endmodule
